addr_gen_arbiter: RTL and testbench

//  Shares one address_generator between two requesters (0 = PCI target side, 1 = local DMA side).

---
 rtl/addr_gen_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_addr_gen_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_arbiter.sv
// Round-robin arbiter that shares one address_generator between the PCI target
// side (0) and the local DMA side (1): validates the command, launches, waits, completes.
module addr_gen_arbiter #(
    parameter int AW      = 4,
    parameter int CW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [CW-1:0] cmd0,
    input  logic [CW-1:0] cmd1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [1:0]    mode0,
    input  logic [1:0]    mode1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          cmpl0,
    output logic          cmpl1,
    output logic          rej0,
    output logic          rej1,
    output logic          err,
    output logic [CW-1:0] ag_cmd,
    output logic [AW-1:0] ag_local_address,
    output logic [1:0]    ag_mode,
    output logic          ag_en,
    input  logic          ag_done
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          ptr, ptr_nxt;
    logic          owner, owner_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    logic          gnt0_nxt, gnt1_nxt;
    logic          cmpl0_nxt, cmpl1_nxt;
    logic          rej0_nxt, rej1_nxt;
    logic          err_nxt;
    logic          ag_en_nxt;
    logic [CW-1:0] ag_cmd_nxt;
    logic [AW-1:0] ag_local_address_nxt;
    logic [1:0]    ag_mode_nxt;

    logic          win;
    logic          win_req;
    logic [CW-1:0] win_cmd;
    logic [AW-1:0] win_addr;
    logic [1:0]    win_mode;

    // READ, WRITE, READ_MUL, READ_LINE and WRITE_INV are the only commands the generator handles.
    function automatic logic cmd_valid(input logic [CW-1:0] c);
        logic v;
        case (c)
            CW'(4'b0110),
            CW'(4'b0111),
            CW'(4'b1100),
            CW'(4'b1110),
            CW'(4'b1111): v = 1'b1;
            default:      v = 1'b0;
        endcase
        return v;
    endfunction

    // A lone requester wins outright; on contention the round-robin pointer decides.
    assign win_req  = req0 | req1;
    assign win      = (req0 & req1) ? ptr : req1;
    assign win_cmd  = win ? cmd1  : cmd0;
    assign win_addr = win ? addr1 : addr0;
    assign win_mode = win ? mode1 : mode0;

    always_comb begin
        state_nxt            = state;
        ptr_nxt              = ptr;
        owner_nxt            = owner;
        tcnt_nxt             = tcnt;
        gnt0_nxt             = gnt0;
        gnt1_nxt             = gnt1;
        cmpl0_nxt            = 1'b0;
        cmpl1_nxt            = 1'b0;
        rej0_nxt             = 1'b0;
        rej1_nxt             = 1'b0;
        err_nxt              = 1'b0;
        ag_en_nxt            = 1'b0;
        ag_cmd_nxt           = ag_cmd;
        ag_local_address_nxt = ag_local_address;
        ag_mode_nxt          = ag_mode;

        case (state)
            IDLE: begin
                // The cycle carrying a reject pulse is skipped so the rejected side can withdraw.
                if (win_req && !(rej0 || rej1)) begin
                    if (cmd_valid(win_cmd)) begin
                        owner_nxt            = win;
                        gnt0_nxt             = ~win;
                        gnt1_nxt             = win;
                        ag_en_nxt            = 1'b1;
                        ag_cmd_nxt           = win_cmd;
                        ag_local_address_nxt = win_addr;
                        ag_mode_nxt          = win_mode;
                        state_nxt            = LAUNCH;
                    end else begin
                        rej0_nxt = ~win;
                        rej1_nxt = win;
                        ptr_nxt  = ~win;
                    end
                end
            end
            LAUNCH: begin
                tcnt_nxt  = '0;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (ag_done) begin
                    cmpl0_nxt = ~owner;
                    cmpl1_nxt = owner;
                    state_nxt = DONE;
                end else if (tcnt == TCNT_LAST) begin
                    cmpl0_nxt = ~owner;
                    cmpl1_nxt = owner;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            DONE: begin
                gnt0_nxt  = 1'b0;
                gnt1_nxt  = 1'b0;
                ptr_nxt   = ~owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs are registered; reset clears everything and abandons any transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            ptr              <= 1'b0;
            owner            <= 1'b0;
            tcnt             <= '0;
            gnt0             <= 1'b0;
            gnt1             <= 1'b0;
            cmpl0            <= 1'b0;
            cmpl1            <= 1'b0;
            rej0             <= 1'b0;
            rej1             <= 1'b0;
            err              <= 1'b0;
            ag_en            <= 1'b0;
            ag_cmd           <= '0;
            ag_local_address <= '0;
            ag_mode          <= '0;
        end else begin
            state            <= state_nxt;
            ptr              <= ptr_nxt;
            owner            <= owner_nxt;
            tcnt             <= tcnt_nxt;
            gnt0             <= gnt0_nxt;
            gnt1             <= gnt1_nxt;
            cmpl0            <= cmpl0_nxt;
            cmpl1            <= cmpl1_nxt;
            rej0             <= rej0_nxt;
            rej1             <= rej1_nxt;
            err              <= err_nxt;
            ag_en            <= ag_en_nxt;
            ag_cmd           <= ag_cmd_nxt;
            ag_local_address <= ag_local_address_nxt;
            ag_mode          <= ag_mode_nxt;
        end
    end

endmodule

// File: tb/tb_addr_gen_arbiter.sv
// Scoreboard bench for addr_gen_arbiter: expected completions are queued when a
// request is driven and compared against completions captured from the DUT.
module tb_addr_gen_arbiter;

    typedef struct packed {
        logic       who;
        logic       err;
        logic [3:0] cmd;
        logic [3:0] addr;
        logic [1:0] mode;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] cmd0 = '0, cmd1 = '0, addr0 = '0, addr1 = '0;
    logic [1:0] mode0 = '0, mode1 = '0;
    logic       gnt0, gnt1, cmpl0, cmpl1, rej0, rej1, err, ag_en;
    logic [3:0] ag_cmd, ag_local_address;
    logic [1:0] ag_mode;
    logic       ag_done = 1'b0;

    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    int   done_delay = 2;
    bit   drop0 = 1'b1, drop1 = 1'b1;
    txn_t exp_q[$];
    txn_t obs_q[$];
    int   rd_idx = 0;

    int   en_cnt = 0, en_cyc = 0, en_dbl = 0, overlap = 0, run0 = 0, gnt0_len = 0;
    int   rej0_cnt = 0, rej1_cnt = 0, cmpl_cyc = 0, bcnt = 0;
    bit   prev_en = 1'b0, armed = 1'b0;

    addr_gen_arbiter #(.AW(4), .CW(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .addr0(addr0), .addr1(addr1), .mode0(mode0), .mode1(mode1),
        .gnt0(gnt0), .gnt1(gnt1), .cmpl0(cmpl0), .cmpl1(cmpl1),
        .rej0(rej0), .rej1(rej1), .err(err),
        .ag_cmd(ag_cmd), .ag_local_address(ag_local_address), .ag_mode(ag_mode),
        .ag_en(ag_en), .ag_done(ag_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Address generator model: done pulses in the done_delay-th BUSY cycle (0 = never).
    always @(negedge clk) begin
        ag_done = 1'b0;
        if (!rst) armed = 1'b0;
        else if (ag_en) begin armed = 1'b1; bcnt = 0; end
        else if (armed) begin
            bcnt++;
            if (done_delay != 0 && bcnt == done_delay) begin ag_done = 1'b1; armed = 1'b0; end
        end
    end

    // Monitor: launches, grant overlap, grant length, rejects and completions.
    always @(negedge clk) begin
        if (ag_en) begin en_cnt++; en_cyc = cyc; if (prev_en) en_dbl++; end
        prev_en = ag_en;
        if (gnt0 && gnt1) overlap++;
        if (gnt0) run0++;
        else if (run0 != 0) begin gnt0_len = run0; run0 = 0; end
        if (rej0) rej0_cnt++;
        if (rej1) rej1_cnt++;
        if (cmpl0 || cmpl1) begin
            obs_q.push_back(txn_t'{who: cmpl1, err: err, cmd: ag_cmd, addr: ag_local_address, mode: ag_mode});
            cmpl_cyc = cyc;
        end
    end

    task automatic run_until(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (cmpl0 && drop0) req0 = 1'b0;
            if (cmpl1 && drop1) req1 = 1'b0;
            if (obs_q.size() >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [17:0] outs;
        bit ok;
        txn_t e, o;
        rst = 1'b0; req0 = 1'b1; cmd0 = 4'b0110; addr0 = 4'h2; mode0 = 2'b00;
        done_delay = 2; drop0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            outs = {gnt0, gnt1, cmpl0, cmpl1, rej0, rej1, err, ag_en, ag_cmd, ag_local_address, ag_mode};
            n_tests++;
            if (outs !== 18'h0) begin n_fail++; $display("FAIL reset_outputs cyc%0d: got %h want 0", i, outs); end
        end
        n_tests++;
        if (en_cnt !== 0) begin n_fail++; $display("FAIL reset_no_en: got %0d launches want 0", en_cnt); end
        exp_q.push_back(txn_t'{who: 1'b0, err: 1'b0, cmd: 4'b0110, addr: 4'h2, mode: 2'b00});
        rst = 1'b1;
        run_until(obs_q.size() + 1, 40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL reset_first_serve: got no completion want req0 served"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : 'x; rd_idx++;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL reset_txn: got %h want %h", o, e); end
        end
    endtask

    task automatic test_single;
        bit ok;
        int e0, rc;
        txn_t e, o;
        @(negedge clk); #1;
        e0 = en_cnt; done_delay = 4; drop0 = 1'b1;
        req0 = 1'b1; cmd0 = 4'b1110; addr0 = 4'b0001; mode0 = 2'b01; rc = cyc;
        exp_q.push_back(txn_t'{who: 1'b0, err: 1'b0, cmd: 4'b1110, addr: 4'b0001, mode: 2'b01});
        run_until(obs_q.size() + 1, 40, ok);
        @(negedge clk); #1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_done: got no completion want one"); end
        n_tests++;
        if (en_cnt - e0 !== 1) begin n_fail++; $display("FAIL single_en_count: got %0d want 1", en_cnt - e0); end
        n_tests++;
        if (en_cyc !== rc + 1) begin n_fail++; $display("FAIL single_latency: got en at %0d want %0d", en_cyc, rc + 1); end
        n_tests++;
        if (gnt0_len !== 6) begin n_fail++; $display("FAIL single_gnt_len: got %0d want 6", gnt0_len); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : 'x; rd_idx++;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL single_txn: got %h want %h", o, e); end
        end
    endtask

    task automatic test_contention;
        bit ok;
        int e0;
        txn_t e, o;
        @(negedge clk); #1;
        rst = 1'b0; done_delay = 3; drop0 = 1'b0; drop1 = 1'b0;
        req0 = 1'b1; cmd0 = 4'b0110; addr0 = 4'h3; mode0 = 2'b00;
        req1 = 1'b1; cmd1 = 4'b0111; addr1 = 4'hA; mode1 = 2'b10;
        @(negedge clk); #1;
        e0 = en_cnt; rst = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(i[0] ? txn_t'{who: 1'b1, err: 1'b0, cmd: 4'b0111, addr: 4'hA, mode: 2'b10}
                                 : txn_t'{who: 1'b0, err: 1'b0, cmd: 4'b0110, addr: 4'h3, mode: 2'b00});
        run_until(obs_q.size() + 4, 80, ok);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL contention_done: got fewer than 4 completions"); end
        n_tests++;
        if (en_cnt - e0 !== 4 || en_dbl !== 0) begin
            n_fail++; $display("FAIL contention_en: got %0d launches (%0d long) want 4 (0)", en_cnt - e0, en_dbl);
        end
        n_tests++;
        if (overlap !== 0) begin n_fail++; $display("FAIL contention_overlap: got %0d cycles want 0", overlap); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : 'x; rd_idx++;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL contention_txn: got %h want %h", o, e); end
        end
    endtask

    task automatic test_invalid;
        bit ok, seen;
        int e0, r0;
        txn_t e, o;
        @(negedge clk); #1;
        e0 = en_cnt; r0 = rej0_cnt; seen = 1'b0; done_delay = 2; drop0 = 1'b1; drop1 = 1'b1;
        req1 = 1'b1; cmd1 = 4'b0000; addr1 = 4'h5; mode1 = 2'b01;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk); #1;
            if (rej1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL invalid_rej1: got no reject want one pulse"); end
        n_tests++;
        if (gnt1 !== 1'b0 || en_cnt !== e0 || rej0_cnt !== r0) begin
            n_fail++; $display("FAIL invalid_side_effects: got gnt1=%b launches=%0d rej0=%0d want 0", gnt1, en_cnt - e0, rej0_cnt - r0);
        end
        cmd1 = 4'b1100; addr1 = 4'h9; mode1 = 2'b10;
        req0 = 1'b1; cmd0 = 4'b1111; addr0 = 4'h4; mode0 = 2'b01;
        exp_q.push_back(txn_t'{who: 1'b0, err: 1'b0, cmd: 4'b1111, addr: 4'h4, mode: 2'b01});
        exp_q.push_back(txn_t'{who: 1'b1, err: 1'b0, cmd: 4'b1100, addr: 4'h9, mode: 2'b10});
        @(negedge clk); #1;
        n_tests++;
        if (rej1 !== 1'b0) begin n_fail++; $display("FAIL invalid_rej_width: got rej1=%b want 0", rej1); end
        run_until(obs_q.size() + 2, 60, ok);
        @(negedge clk); #1;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL invalid_followup: got fewer than 2 completions"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : 'x; rd_idx++;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL invalid_txn: got %h want %h", o, e); end
        end
    endtask

    task automatic test_timeout;
        bit ok;
        txn_t e, o;
        @(negedge clk); #1;
        done_delay = 0; drop0 = 1'b1;
        req0 = 1'b1; cmd0 = 4'b0111; addr0 = 4'hC; mode0 = 2'b00;
        exp_q.push_back(txn_t'{who: 1'b0, err: 1'b1, cmd: 4'b0111, addr: 4'hC, mode: 2'b00});
        run_until(obs_q.size() + 1, 40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL timeout_done: got no completion want cmpl0 with err"); end
        n_tests++;
        if (cmpl_cyc - en_cyc !== 17) begin n_fail++; $display("FAIL timeout_latency: got %0d want 17 cycles from launch", cmpl_cyc - en_cyc); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_tests++;
        if ({gnt0, err, cmpl0} !== 3'b000) begin n_fail++; $display("FAIL timeout_idle: got gnt0/err/cmpl0=%b want 000", {gnt0, err, cmpl0}); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : 'x; rd_idx++;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL timeout_txn: got %h want %h", o, e); end
        end
    endtask

    task automatic test_midop_reset;
        bit ok, seen;
        int n0;
        logic [7:0] ctl;
        txn_t e, o;
        @(negedge clk); #1;
        done_delay = 0; seen = 1'b0;
        req0 = 1'b1; cmd0 = 4'b0110; addr0 = 4'h7; mode0 = 2'b01;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk); #1;
            if (ag_en) seen = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; end
        n0 = obs_q.size();
        rst = 1'b0; req0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            ctl = {gnt0, gnt1, cmpl0, cmpl1, rej0, rej1, err, ag_en};
            n_tests++;
            if (!seen || ctl !== 8'h0) begin n_fail++; $display("FAIL midop_reset_outputs: got launch=%b ctl=%b want launch=1 ctl=0", seen, ctl); end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; end
        n_tests++;
        if (obs_q.size() !== n0) begin n_fail++; $display("FAIL midop_no_cmpl: got %0d completions want 0", obs_q.size() - n0); end
        done_delay = 3; drop0 = 1'b1; drop1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1; cmd1 = 4'b1110; addr1 = 4'h8; mode1 = 2'b00;
        exp_q.push_back(txn_t'{who: 1'b0, err: 1'b0, cmd: 4'b0110, addr: 4'h7, mode: 2'b01});
        exp_q.push_back(txn_t'{who: 1'b1, err: 1'b0, cmd: 4'b1110, addr: 4'h8, mode: 2'b00});
        run_until(obs_q.size() + 2, 60, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL midop_rerequest: got fewer than 2 completions"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (rd_idx < obs_q.size()) ? obs_q[rd_idx] : 'x; rd_idx++;
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL midop_txn: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_invalid();
        test_timeout();
        test_midop_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
